ahb_rx_fifo_slave: RTL
======================

# ahb_rx_fifo_slave

AHB-Lite slave that buffers 16-bit words pushed by local logic, for example RS485 receive words, and returns them to an AHB master through memory-mapped reads. It sits on the CoreAHBLite slave port that the FIC-side read master targets at its fixed data address. It is the responder end of that single-transfer, non-sequential read flow. A DATA read pops one word; a STATUS read and CTRL writes manage the buffer.

## Interface
- DEPTH, 16: FIFO depth in words; power of two, minimum 2.
- WAIT_MAX, 15: maximum wait states inserted on an empty DATA read (only when `RXF_EMPTY_WAIT_EN` is defined).
- HCLK  in  1  bus clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  32  address; only HADDR[3:2] is decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ or SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  accepted but ignored; all accesses are treated as 16-bit.
- HWDATA  in  32  write data; only [15:0] is used.
- HREADY  in  1  bus-level ready (HREADYIN).
- HREADYOUT  out  1  slave ready; reset value 1.
- HRESP  out  2  00 = OKAY, 01 = ERROR; reset value 00.
- HRDATA  out  16  read data; reset value 0x0000.
- WR_EN  in  1  push strobe from logic.
- WR_DATA  in  16  push data.
- FULL  out  1  FIFO full; reset value 0.
- EMPTY  out  1  FIFO empty; reset value 1.
- OVERFLOW  out  1  sticky flag: a push was dropped because the FIFO was full; reset value 0.

## Operation
- Address phase: a transfer is accepted when HSEL & HREADY & HTRANS[1]. On acceptance, HADDR[3:2] and HWRITE are registered. The data phase runs in the following cycle(s).
- Register map:
  - 0x0 DATA (read only): read returns the FIFO head and pops it. Writes are ignored.
  - 0x4 STATUS (read only): [0] EMPTY, [1] FULL, [2] OVERFLOW, [8+CW-1:8] count, where CW = clog2(DEPTH)+1. All other bits read 0.
  - 0x8 CTRL (write only): bit0 = flush (empties the FIFO, clears OVERFLOW); bit1 = clear OVERFLOW. Reads return 0.
  - 0xC: reserved; reads return 0, writes are ignored, response is OKAY.
- Push: when WR_EN=1 and not FULL, WR_DATA is written at the write pointer.
  - WR_EN=1 while FULL: the word is dropped and OVERFLOW is set.
  - Push and pop in the same cycle: both take effect; count is unchanged. Push while FULL is still dropped, even if a pop occurs in the same cycle.
- Flush and push in the same cycle: flush wins; the pushed word is discarded.
- Pointers are CW-1 bits wide and wrap modulo DEPTH. Count ranges 0..DEPTH.
- FSM states:
  - IDLE: data phase with no wait; HREADYOUT=1, HRESP=OKAY.
  - RD_WAIT: empty DATA read with wait enabled; HREADYOUT=0; a wait counter increments each cycle.
  - ERR1: HREADYOUT=0, HRESP=ERROR.
  - ERR2: HREADYOUT=1, HRESP=ERROR.
- Transitions:
  - DATA read while EMPTY (macro defined) → RD_WAIT.
  - RD_WAIT with EMPTY=0 → IDLE; the read completes and pops.
  - RD_WAIT with counter = WAIT_MAX → ERR1 → ERR2 → IDLE. No pop occurs.
- Reset mid-transfer: returns to IDLE; FIFO is emptied; all outputs take their reset values.

## Timing
- HRDATA is driven from the registered address and the FIFO head, so a non-empty DATA read has zero wait states. If the address phase is cycle T, HRDATA is valid in T+1 and the pop takes effect at the end of T+1.
- Back-to-back DATA reads each return a successive word, one word per cycle.
- A CTRL write acts at the clock edge that ends its data phase, where HWDATA is sampled.
- A STATUS read reflects the state at the start of its data phase.
- FULL, EMPTY and OVERFLOW are registered and update one cycle after the push, pop or flush edge.
- Push during RD_WAIT: EMPTY falls the cycle after the push. The data phase completes in that cycle with HREADYOUT=1 and HRDATA equal to the pushed word.
- An ERROR response always occupies exactly two cycles (ERR1, then ERR2).

## Configuration
- `RXF_EMPTY_WAIT_EN` defined: empty DATA reads behave as RD_WAIT with a WAIT_MAX timeout followed by the two-cycle ERROR response.
- Not defined: an empty DATA read returns 0x0000 with OKAY and zero wait states, and does not pop. RD_WAIT, ERR1, ERR2 and the wait counter are not compiled in.

## Structure
- Shared package: register offset constants (DATA=2'b00, STATUS=2'b01, CTRL=2'b10), HTRANS and HRESP encodings, and the FSM state encoding.
- One sub-module: `rxf_fifo_core`, holding storage, pointers, count, FULL/EMPTY and OVERFLOW, with push, pop and flush inputs.
- The AHB decode and FSM live in the top level.

## Test plan
- Push 0x1111, 0x2222, 0x3333; issue three back-to-back DATA reads → HRDATA = 0x1111, 0x2222, 0x3333, each with zero wait; EMPTY=1 afterwards.
- Push 17 words into DEPTH=16 → FULL=1, OVERFLOW=1, STATUS = 0x1006. Write CTRL=0x2 → OVERFLOW=0. Write CTRL=0x1 → STATUS = 0x0001.
- Wrap-around: push 10, pop 10, push 12, pop 12 → data is returned in order; count is 0 at the end.
- Macro defined, FIFO empty: issue a DATA read, push 0xBEEF 3 cycles later → HREADYOUT is low for 4 cycles, then the read returns 0xBEEF with OKAY.
- Macro defined, FIFO empty, no push → HREADYOUT is low for WAIT_MAX+1 cycles, then ERROR for 2 cycles; HRDATA = 0x0000.
- Push and pop in the same cycle at count 1 → count stays 1. Assert HRESETn during RD_WAIT → HREADYOUT=1, HRESP=00, EMPTY=1.

Source files
------------

// File: rtl/ahb_rx_fifo_slave_pkg.sv
// Shared definitions for the AHB receive FIFO slave: register offsets,
// AHB encodings, FSM state encoding and the STATUS word layout.
package ahb_rx_fifo_slave_pkg;

    // Register offsets, decoded from HADDR[3:2]
    localparam logic [1:0] RegData   = 2'b00;
    localparam logic [1:0] RegStatus = 2'b01;
    localparam logic [1:0] RegCtrl   = 2'b10;
    localparam logic [1:0] RegRsvd   = 2'b11;

    // HTRANS encodings
    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    // HRESP encodings
    localparam logic [1:0] HrespOkay  = 2'b00;
    localparam logic [1:0] HrespError = 2'b01;

    // Data-phase FSM states
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRdWait = 2'b01,
        StErr1   = 2'b10,
        StErr2   = 2'b11
    } rxf_state_e;

    // STATUS layout: [0] empty, [1] full, [2] overflow, [15:8] count.
    function automatic logic [15:0] status_word(input logic       empty,
                                                input logic       full,
                                                input logic       overflow,
                                                input logic [7:0] count);
        return {count, 5'b00000, overflow, full, empty};
    endfunction

endpackage

// File: rtl/rxf_fifo_core.sv
// Storage, pointers, occupancy count and registered FULL/EMPTY/OVERFLOW flags
// for the receive FIFO. Flush has priority over push and pop.
module rxf_fifo_core #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned CW    = $clog2(DEPTH) + 1,
    localparam int unsigned PW    = CW - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [15:0]   push_data,
    input  logic          pop,
    input  logic          flush,
    input  logic          clr_ovf,
    output logic [15:0]   head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          empty_next
);

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, ovf_q, ovf_d;
    logic          push_ok, pop_ok;

    // Next-state for pointers, count and the sticky overflow flag.
    always_comb begin
        push_ok  = push & ~full_q & ~flush;
        pop_ok   = pop & ~empty_q & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
            // A drop in the same cycle as a clear still leaves the flag set.
            if (clr_ovf) begin
                ovf_d = 1'b0;
            end
            if (push && full_q) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
            ovf_q    <= ovf_d;
        end
    end

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head       = mem[rd_ptr_q];
    assign count      = count_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign overflow   = ovf_q;
    assign empty_next = (count_d == '0);

endmodule

// File: rtl/ahb_rx_fifo_slave.sv
// AHB-Lite slave returning words from a local receive FIFO.
// DATA reads pop the head, STATUS reports flags/count, CTRL flushes or clears
// overflow. Optional feature macro: RXF_EMPTY_WAIT_EN (stall empty DATA reads,
// then answer with a two-cycle ERROR after WAIT_MAX+1 wait cycles).
module ahb_rx_fifo_slave
    import ahb_rx_fifo_slave_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [15:0] HRDATA,
    input  logic        WR_EN,
    input  logic [15:0] WR_DATA,
    output logic        FULL,
    output logic        EMPTY,
    output logic        OVERFLOW
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          accept;
    logic          dphase_q;
    logic [1:0]    addr_q;
    logic          write_q;
    logic          rd_phase;
    logic          phase_done;
    logic          pop;
    logic          ctrl_wr;
    logic          flush;
    logic          clr_ovf;
    logic          ready;
    logic [1:0]    resp;
    logic [15:0]   rdata;
    logic [15:0]   fifo_head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_ovf;
    logic          fifo_empty_next;

    assign accept = HSEL & HREADY & ((HTRANS == HtransNonseq) | (HTRANS == HtransSeq));

    // Address-phase capture; held while the bus is stalled.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dphase_q <= 1'b0;
            addr_q   <= RegData;
            write_q  <= 1'b0;
        end else if (HREADY) begin
            dphase_q <= accept;
            if (accept) begin
                addr_q  <= HADDR[3:2];
                write_q <= HWRITE;
            end
        end
    end

    assign rd_phase = dphase_q & ~write_q;
    assign pop      = rd_phase & (addr_q == RegData) & ~fifo_empty & phase_done;
    assign ctrl_wr  = dphase_q & write_q & (addr_q == RegCtrl) & phase_done;
    assign flush    = ctrl_wr & HWDATA[0];
    assign clr_ovf  = ctrl_wr & HWDATA[1];

`ifdef RXF_EMPTY_WAIT_EN
    localparam int unsigned    WCW      = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [WCW-1:0] WaitLast = WCW'(WAIT_MAX);

    rxf_state_e     state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           start_wait;

    // Look at the post-edge occupancy so a read racing the last pop still waits.
    assign start_wait = accept & ~HWRITE & (HADDR[3:2] == RegData) & fifo_empty_next;

    // Data-phase FSM: next state, wait counter and bus response.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        ready      = 1'b1;
        resp       = HrespOkay;
        phase_done = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (start_wait) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (!fifo_empty) begin
                    state_d = start_wait ? StRdWait : StIdle;
                end else begin
                    ready      = 1'b0;
                    phase_done = 1'b0;
                    if (wait_cnt_q == WaitLast) begin
                        state_d = StErr1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            StErr1: begin
                ready      = 1'b0;
                resp       = HrespError;
                phase_done = 1'b0;
                state_d    = StErr2;
            end
            StErr2: begin
                resp       = HrespError;
                phase_done = 1'b0;
                state_d    = start_wait ? StRdWait : StIdle;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    // Every data phase completes immediately; empty DATA reads return zero.
    assign ready      = 1'b1;
    assign resp       = HrespOkay;
    assign phase_done = 1'b1;

    logic unused_cfg;
    assign unused_cfg = fifo_empty_next ^ (WAIT_MAX == 32'd0);
`endif

    // Read mux: FIFO head (zero when empty), STATUS snapshot, zero otherwise.
    always_comb begin
        rdata = '0;
        if (rd_phase && phase_done) begin
            case (addr_q)
                RegData: begin
                    if (!fifo_empty) begin
                        rdata = fifo_head;
                    end
                end
                RegStatus: rdata = status_word(fifo_empty, fifo_full, fifo_ovf, 8'(fifo_count));
                default:   rdata = '0;
            endcase
        end
    end

    rxf_fifo_core #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .push       (WR_EN),
        .push_data  (WR_DATA),
        .pop        (pop),
        .flush      (flush),
        .clr_ovf    (clr_ovf),
        .head       (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .overflow   (fifo_ovf),
        .empty_next (fifo_empty_next)
    );

    assign HREADYOUT = ready;
    assign HRESP     = resp;
    assign HRDATA    = rdata;
    assign FULL      = fifo_full;
    assign EMPTY     = fifo_empty;
    assign OVERFLOW  = fifo_ovf;

    logic unused_bits;
    assign unused_bits = ^{HSIZE, HWDATA[31:2], HADDR[31:4], HADDR[1:0]};

endmodule
